mem_rd_seq: RTL and testbench
=============================

Name: mem_rd_seq

Overview:
- Read sequencer that drives the initiator side of the team's asynchronous-read memory interface (addr / cs / rd_en in, data out).
- On a start command it reads a block of consecutive words and presents each word on a valid/ready stream.
- It keeps a running checksum of the words it delivers.
- It sits between control logic and any ROM/RAM block that uses the addr/data_out/rd_en/cs port set.

Parameters:
ADDR_W, 4, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 4, memory data width
RD_LAT, 1, cycles the address/cs/rd_en are held before mem_data_in is sampled (legal range >= 1)
SUM_W, 8, checksum width; sum taken modulo 2^SUM_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle command pulse; honoured only in IDLE
abort  input  1  synchronous cancel of an active command
base_addr  input  ADDR_W  first address; sampled with start
count  input  ADDR_W+1  number of words to read; sampled with start; range 0..2^ADDR_W
mem_addr  output  ADDR_W  address to memory
mem_cs  output  1  chip select to memory
mem_rd_en  output  1  read enable to memory
mem_data_in  input  DATA_W  data from memory
out_data  output  DATA_W  word being delivered
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the word
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a command completes normally
checksum  output  SUM_W  sum of accepted words for the current/last command

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_addr=0, mem_cs=0, mem_rd_en=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0; internal address, remaining and latency counters = 0.
- All outputs are registered.
- States: IDLE, ISSUE, HOLD, DONE.
- IDLE:
  - start=1 and count!=0: latch base_addr as the current address and count as remaining, clear checksum, go to ISSUE.
  - start=1 and count=0: clear checksum, go to DONE; no memory access.
  - start while busy is ignored.
- ISSUE:
  - mem_addr = current address, mem_cs=1, mem_rd_en=1, held for exactly RD_LAT cycles.
  - In the last of those cycles, mem_data_in is captured into out_data and the block moves to HOLD.
  - out_valid is asserted in the first HOLD cycle.
- HOLD:
  - mem_cs=0 and mem_rd_en=0; mem_addr keeps its last value.
  - out_valid=1 and out_data stays stable until out_ready=1 (handshake: out_valid & out_ready in the same cycle).
  - On handshake: checksum += out_data (mod 2^SUM_W); address += 1 (wraps 2^ADDR_W-1 to 0); remaining -= 1; out_valid drops next cycle.
  - Next state is DONE if remaining becomes 0, otherwise ISSUE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. checksum holds its value until the next start.
- Latency and throughput:
  - start at cycle N: first out_valid at N+1+RD_LAT.
  - With out_ready held at 1, one word every RD_LAT+1 cycles.
  - done is asserted the cycle after the final handshake.
- abort:
  - abort=1 in any state other than IDLE: next cycle state=IDLE, out_valid=0, mem_cs=0, mem_rd_en=0, no done pulse. checksum keeps the partial sum.
  - abort takes priority over a handshake in the same cycle; that word is not counted.
  - abort in IDLE has no effect.
- count = 2^ADDR_W reads every address exactly once, starting at base_addr and wrapping.
- Asserting rst_n low mid-command returns everything to reset values immediately; no done pulse is produced.

Test Plan:
- The bench memory model returns mem_data_in = ~mem_addr, combinationally.
- Test 1: base 0, count 4, out_ready=1 -> words F,E,D,C; out_valid first at start+2; one word every 2 cycles; done one cycle after the 4th handshake; checksum=0x36.
- Test 2: base 14, count 4 -> addresses 14,15,0,1; words 1,0,F,E; checksum=0x1E.
- Test 3: count 0 -> done at start+1 with busy=1 for that cycle; mem_cs never asserted; checksum=0.
- Test 4: base 2, count 3, out_ready low for 5 cycles on word 2 -> out_data=C stays stable with out_valid=1; mem_cs=0 while stalled; final checksum=D+C+B=0x24.
- Test 5: base 0, count 8, abort asserted during the HOLD of the 3rd word -> IDLE next cycle, no done, checksum=0x1D; a new start while busy is ignored.
- Test 6: reset asserted during ISSUE -> all outputs 0 immediately. With RD_LAT=3: mem_cs held for 3 cycles per word and the first out_valid at start+4.

Source files
------------

// File: rtl/mem_rd_seq.sv
// rtl/mem_rd_seq.sv - block read sequencer for async-read memories with stream output and checksum
//
// Reads `count` consecutive words starting at `base_addr` from a memory that
// uses the addr/cs/rd_en/data_out port set, and delivers each word on a
// valid/ready stream while keeping a running checksum of accepted words.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          command pulse (IDLE only) and synchronous cancel
//   base_addr, count      first address and word count, sampled with start
//   mem_addr, mem_cs,     memory request; held for RD_LAT cycles per word
//   mem_rd_en
//   mem_data_in           memory read data, captured in the last request cycle
//   out_data, out_valid,  delivered word stream
//   out_ready
//   busy, done            activity flag and one-cycle completion pulse
//   checksum              sum of accepted words, modulo 2^SUM_W

module mem_rd_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1,
    parameter int SUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cs,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  checksum
);

    // The latency counter runs from RD_LAT-1 down to 0; it needs at least one bit.
    localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
    localparam logic [LAT_W-1:0]  LAT_ZERO = '0;
    localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ZERO = '0;
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     remaining_q;
    logic [LAT_W-1:0]    lat_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_cs_q;
    logic                mem_rd_en_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                done_q;
    logic [SUM_W-1:0]    checksum_q;

    // Next-value helpers used by the handshake path.
    logic [ADDR_W-1:0]   addr_inc_d;
    logic [ADDR_W:0]     rem_dec_d;
    logic [SUM_W-1:0]    sum_acc_d;
    logic                handshake_d;

    assign addr_inc_d  = addr_q + ADDR_ONE;           // wraps 2^ADDR_W-1 -> 0
    assign rem_dec_d   = remaining_q - REM_ONE;
    assign sum_acc_d   = checksum_q + SUM_W'(out_data_q);
    assign handshake_d = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            lat_q       <= '0;
            mem_addr_q  <= '0;
            mem_cs_q    <= 1'b0;
            mem_rd_en_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                // Cancel wins over everything, including a same-cycle handshake,
                // so the word on the stream is dropped and not summed.
                state_q     <= S_IDLE;
                mem_cs_q    <= 1'b0;
                mem_rd_en_q <= 1'b0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            checksum_q <= '0;
                            busy_q     <= 1'b1;
                            if (count != REM_ZERO) begin
                                addr_q      <= base_addr;
                                remaining_q <= count;
                                lat_q       <= LAT_LAST;
                                mem_addr_q  <= base_addr;
                                mem_cs_q    <= 1'b1;
                                mem_rd_en_q <= 1'b1;
                                state_q     <= S_ISSUE;
                            end else begin
                                // Empty command completes without touching memory.
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end
                    end

                    S_ISSUE: begin
                        if (lat_q == LAT_ZERO) begin
                            out_data_q  <= mem_data_in;
                            out_valid_q <= 1'b1;
                            mem_cs_q    <= 1'b0;
                            mem_rd_en_q <= 1'b0;
                            state_q     <= S_HOLD;
                        end else begin
                            lat_q <= lat_q - LAT_ONE;
                        end
                    end

                    S_HOLD: begin
                        if (handshake_d) begin
                            checksum_q  <= sum_acc_d;
                            addr_q      <= addr_inc_d;
                            remaining_q <= rem_dec_d;
                            out_valid_q <= 1'b0;
                            if (remaining_q == REM_ONE) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                mem_addr_q  <= addr_inc_d;
                                mem_cs_q    <= 1'b1;
                                mem_rd_en_q <= 1'b1;
                                lat_q       <= LAT_LAST;
                                state_q     <= S_ISSUE;
                            end
                        end
                    end

                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end

                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_cs    = mem_cs_q;
    assign mem_rd_en = mem_rd_en_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_mem_rd_seq.sv
// tb/tb_mem_rd_seq.sv - self-checking bench for mem_rd_seq at read latencies 1 and 3

module tb_mem_rd_seq;

    localparam int AW   = 4;
    localparam int DW   = 4;
    localparam int SW   = 8;
    localparam int NDUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;

    logic          abort       [NDUT];
    logic          out_ready   [NDUT];
    logic [AW-1:0] mem_addr    [NDUT];
    logic          mem_cs      [NDUT];
    logic          mem_rd_en   [NDUT];
    logic [DW-1:0] mem_data_in [NDUT];
    logic [DW-1:0] out_data    [NDUT];
    logic          out_valid   [NDUT];
    logic          busy        [NDUT];
    logic          done        [NDUT];
    logic [SW-1:0] checksum    [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign mem_data_in[g] = ~mem_addr[g];
        mem_rd_seq #(
            .ADDR_W(AW), .DATA_W(DW), .RD_LAT((g == 0) ? 1 : 3), .SUM_W(SW)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .abort(abort[g]),
            .base_addr(base_addr), .count(count),
            .mem_addr(mem_addr[g]), .mem_cs(mem_cs[g]), .mem_rd_en(mem_rd_en[g]),
            .mem_data_in(mem_data_in[g]),
            .out_data(out_data[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .busy(busy[g]), .done(done[g]), .checksum(checksum[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    int fin_sum  [NDUT];
    bit fin_done [NDUT];
    int fin_hs   [NDUT];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=0x%0h required=0x%0h", name, d, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            chk({tag, "_addr"}, d, mem_addr[d], 0);
            chk({tag, "_cs"}, d, mem_cs[d], 0);
            chk({tag, "_rd"}, d, mem_rd_en[d], 0);
            chk({tag, "_data"}, d, out_data[d], 0);
            chk({tag, "_valid"}, d, out_valid[d], 0);
            chk({tag, "_busy"}, d, busy[d], 0);
            chk({tag, "_done"}, d, done[d], 0);
            chk({tag, "_sum"}, d, checksum[d], 0);
        end
    endtask

    // Per-DUT driver and reference: the expected stream is word i = ~(base+i),
    // the expected checksum is the plain sum of accepted words.
    task automatic drv(input int d, input logic [AW-1:0] b, input int n,
                       input int stall_word, input int stall_len,
                       input int abort_word, input int abort_k, input bit rnd);
        int lat = (d == 0) ? 1 : 3;
        int hs = 0;
        int last_hs_k = -1;
        int first_v = -1;
        int cs_run = 0;
        int stalled = 0;
        int exp_sum = 0;
        bit prev_wait = 0;
        bit fin = 0;
        bit aborted = 0;
        bit rdy;
        bit ab;
        logic [DW-1:0] prev_data = '0;
        logic [AW-1:0] cur_a;
        logic [DW-1:0] exp_w;
        fin_done[d] = 0;
        for (int k = 1; k <= 600 && !fin; k++) begin
            @(negedge clk);
            abort[d] = 1'b0;
            cur_a = b + AW'(hs);
            exp_w = ~cur_a;
            if (aborted) begin
                chk("abort_valid", d, out_valid[d], 0);
                chk("abort_cs", d, mem_cs[d], 0);
                chk("abort_busy", d, busy[d], 0);
                chk("abort_done", d, done[d], 0);
                chk("abort_sum", d, checksum[d], exp_sum & 255);
                fin = 1;
            end else if (fin_done[d]) begin
                chk("idle_busy", d, busy[d], 0);
                chk("idle_done", d, done[d], 0);
                chk("idle_sum", d, checksum[d], exp_sum & 255);
                fin = 1;
            end else begin
                chk("busy", d, busy[d], 1);
                if (done[d]) begin
                    chk("done_words", d, hs, n);
                    chk("done_timing", d, k, (n == 0) ? 1 : last_hs_k + 1);
                    chk("done_sum", d, checksum[d], exp_sum & 255);
                    chk("done_cs", d, mem_cs[d], 0);
                    fin_done[d] = 1;
                end else begin
                    if (mem_cs[d]) begin
                        chk("issue_addr", d, mem_addr[d], cur_a);
                        chk("issue_rd", d, mem_rd_en[d], 1);
                        chk("issue_novalid", d, out_valid[d], 0);
                        cs_run++;
                    end else begin
                        if (cs_run > 0) chk("cs_len", d, cs_run, lat);
                        cs_run = 0;
                    end
                    if (prev_wait) begin
                        chk("stall_valid", d, out_valid[d], 1);
                        chk("stall_data", d, out_data[d], prev_data);
                    end
                    if (out_valid[d]) begin
                        if (first_v < 0) begin
                            first_v = k;
                            chk("first_valid", d, k, 1 + lat);
                        end
                        chk("word", d, out_data[d], exp_w);
                        chk("hold_addr", d, mem_addr[d], cur_a);
                        if (rnd) rdy = 1'($urandom_range(0, 1));
                        else rdy = !(hs == stall_word && stalled < stall_len);
                        if (!rdy && hs == stall_word) stalled++;
                        ab = (hs == abort_word) || (k == abort_k);
                    end else begin
                        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                        ab = (k == abort_k);
                    end
                    out_ready[d] = rdy;
                    abort[d] = ab;
                    if (ab) begin
                        aborted = 1;
                    end else if (out_valid[d] && rdy) begin
                        if (!rnd && last_hs_k >= 0 && !(stall_len > 0 && hs == stall_word))
                            chk("spacing", d, k - last_hs_k, lat + 1);
                        exp_sum += int'(exp_w);
                        hs++;
                        last_hs_k = k;
                    end
                    prev_wait = out_valid[d] && !rdy && !ab;
                    prev_data = out_data[d];
                end
            end
        end
        if (!fin) chk("timeout", d, 1, 0);
        abort[d] = 1'b0;
        out_ready[d] = 1'b0;
        fin_sum[d] = int'(checksum[d]);
        fin_hs[d] = hs;
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input int n, input int sw, input int sl,
                           input int aw, input int ak, input bit rnd, input bit busy_start);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        count = (AW + 1)'(n);
        fork
            drv(0, b, n, sw, sl, aw, ak, rnd);
            drv(1, b, n, sw, sl, aw, ak, rnd);
            begin
                @(negedge clk);
                start = 1'b0;
                if (busy_start) begin
                    @(negedge clk);
                    start = 1'b1;
                    base_addr = b + 4'd7;
                    count = 5'd1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
    endtask

    typedef struct {
        logic [AW-1:0] b;
        int n;
        int sw;
        int sl;
        int aw;
        bit bs;
        int exp_sum;
        bit exp_done;
        int exp_hs;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{b: 4'd0,  n: 4,  sw: -1, sl: 0, aw: -1, bs: 0, exp_sum: 'h36, exp_done: 1, exp_hs: 4};
        vecs[1] = '{b: 4'd14, n: 4,  sw: -1, sl: 0, aw: -1, bs: 0, exp_sum: 'h1E, exp_done: 1, exp_hs: 4};
        vecs[2] = '{b: 4'd0,  n: 0,  sw: -1, sl: 0, aw: -1, bs: 0, exp_sum: 'h00, exp_done: 1, exp_hs: 0};
        vecs[3] = '{b: 4'd2,  n: 3,  sw: 1,  sl: 5, aw: -1, bs: 0, exp_sum: 'h24, exp_done: 1, exp_hs: 3};
        vecs[4] = '{b: 4'd0,  n: 8,  sw: -1, sl: 0, aw: 2,  bs: 1, exp_sum: 'h1D, exp_done: 0, exp_hs: 2};
        vecs[5] = '{b: 4'd5,  n: 16, sw: -1, sl: 0, aw: -1, bs: 0, exp_sum: 'h78, exp_done: 1, exp_hs: 16};

        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        for (int d = 0; d < NDUT; d++) begin
            abort[d] = 1'b0;
            out_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].b, vecs[i].n, vecs[i].sw, vecs[i].sl, vecs[i].aw, -1, 1'b0, vecs[i].bs);
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("tbl%0d_sum", i), d, fin_sum[d], vecs[i].exp_sum);
                chk($sformatf("tbl%0d_done", i), d, fin_done[d], vecs[i].exp_done);
                chk($sformatf("tbl%0d_words", i), d, fin_hs[d], vecs[i].exp_hs);
            end
        end

        // Abort issued while idle must not disturb anything.
        @(negedge clk);
        abort[0] = 1'b1;
        abort[1] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        abort[1] = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            chk("idle_abort_busy", d, busy[d], 0);
            chk("idle_abort_sum", d, checksum[d], fin_sum[d]);
        end

        // Reset in the middle of a read: everything returns to zero at once.
        @(negedge clk);
        start = 1'b1;
        base_addr = 4'd5;
        count = 5'd4;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < NDUT; d++) chk("pre_reset_cs", d, mem_cs[d], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                chk("post_reset_done", d, done[d], 0);
                chk("post_reset_cs", d, mem_cs[d], 0);
            end
        end

        for (int r = 0; r < 40; r++) begin
            logic [AW-1:0] rb;
            int rn;
            int rk;
            rb = AW'($urandom_range(0, 15));
            rn = $urandom_range(0, 16);
            rk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
            run_cmd(rb, rn, -1, 0, -1, rk, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
